// File: rtl/hazard_if.sv
// hazard_if: decoded ID-stage fields, branch outcome and hazard controls
interface hazard_if;
  logic [4:0]  i_ID_data_RSAddr;
  logic [4:0]  i_ID_data_RTAddr;
  logic        i_ID_ctrl_UsesRS;
  logic        i_ID_ctrl_UsesRT;
  logic [4:0]  i_ID_data_DstAddr;
  logic        i_ID_ctrl_RegWrite;
  logic        i_ID_ctrl_MemRead;
  logic        i_MEM_ctrl_BranchTaken;
  logic        o_IF_ctrl_PCWrite;
  logic        o_ID_ctrl_IFIDWrite;
  logic        o_ID_ctrl_IFIDFlush;
  logic        o_EX_ctrl_Bubble;
  logic        o_MEM_ctrl_Flush;
  logic [15:0] o_stat_StallCnt;
  logic [15:0] o_stat_FlushCnt;
  modport master (
    output i_ID_data_RSAddr, i_ID_data_RTAddr, i_ID_ctrl_UsesRS, i_ID_ctrl_UsesRT,
           i_ID_data_DstAddr, i_ID_ctrl_RegWrite, i_ID_ctrl_MemRead, i_MEM_ctrl_BranchTaken,
    input  o_IF_ctrl_PCWrite, o_ID_ctrl_IFIDWrite, o_ID_ctrl_IFIDFlush, o_EX_ctrl_Bubble,
           o_MEM_ctrl_Flush, o_stat_StallCnt, o_stat_FlushCnt
  );
  modport slave (
    input  i_ID_data_RSAddr, i_ID_data_RTAddr, i_ID_ctrl_UsesRS, i_ID_ctrl_UsesRT,
           i_ID_data_DstAddr, i_ID_ctrl_RegWrite, i_ID_ctrl_MemRead, i_MEM_ctrl_BranchTaken,
    output o_IF_ctrl_PCWrite, o_ID_ctrl_IFIDWrite, o_ID_ctrl_IFIDFlush, o_EX_ctrl_Bubble,
           o_MEM_ctrl_Flush, o_stat_StallCnt, o_stat_FlushCnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use/RAW stall and taken-branch flush control with EX/MEM/WB shadow scoreboard
module hazard_ctrl #(
  parameter bit FORWARDING = 1'b1,
  parameter bit WB_BYPASS  = 1'b1
) (
  input  logic     clk,
  input  logic     nrst,
  hazard_if.slave  hz
);
  typedef struct packed {
    logic       vld;
    logic [4:0] dst;
    logic       wr;
    logic       ld;
  } slot_t;
  typedef enum logic [1:0] {RUN, STALL, FLUSH} mode_e;
  slot_t       ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [15:0] stall_q, stall_d, flush_q, flush_d;
  logic [2:0]  hit, ld, en;
  logic        hazard;
  mode_e       mode;
  logic [4:0]  ctl;
  function automatic logic match(slot_t s, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt);
    return s.vld && s.wr && s.dst != 5'd0 && ((urs && s.dst == rs) || (urt && s.dst == rt));
  endfunction
  assign hit = {match(wb_q,  hz.i_ID_data_RSAddr, hz.i_ID_data_RTAddr, hz.i_ID_ctrl_UsesRS, hz.i_ID_ctrl_UsesRT),
                match(mem_q, hz.i_ID_data_RSAddr, hz.i_ID_data_RTAddr, hz.i_ID_ctrl_UsesRS, hz.i_ID_ctrl_UsesRT),
                match(ex_q,  hz.i_ID_data_RSAddr, hz.i_ID_data_RTAddr, hz.i_ID_ctrl_UsesRS, hz.i_ID_ctrl_UsesRT)};
  assign ld  = {wb_q.ld, mem_q.ld, ex_q.ld};
  // with forwarding only a load still in EX blocks; otherwise every writer blocks until it retires
  assign en     = FORWARDING ? (ld & 3'b001) : {!WB_BYPASS, 2'b11};
  assign hazard = |(hit & en);
  // mode priority and the pipeline controls it implies; reset forces nops everywhere
  always_comb begin
    mode = hz.i_MEM_ctrl_BranchTaken ? FLUSH : hazard ? STALL : RUN;
    ctl  = !nrst ? 5'b00111 : mode == FLUSH ? 5'b11111 : mode == STALL ? 5'b00010 : 5'b11000;
  end
  assign {hz.o_IF_ctrl_PCWrite, hz.o_ID_ctrl_IFIDWrite, hz.o_ID_ctrl_IFIDFlush,
          hz.o_EX_ctrl_Bubble, hz.o_MEM_ctrl_Flush} = ctl;
  assign hz.o_stat_StallCnt = stall_q;
  assign hz.o_stat_FlushCnt = flush_q;
  // scoreboard shift: bubbles enter EX on stall/flush, squashed EX is dropped on flush
  always_comb begin
    ex_d    = mode == RUN ? slot_t'({1'b1, hz.i_ID_data_DstAddr, hz.i_ID_ctrl_RegWrite, hz.i_ID_ctrl_MemRead}) : slot_t'(0);
    mem_d   = mode == FLUSH ? slot_t'(0) : ex_q;
    wb_d    = mem_q;
    stall_d = stall_q + 16'(mode == STALL && stall_q != 16'hFFFF);
    flush_d = flush_q + 16'(mode == FLUSH && flush_q != 16'hFFFF);
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nrst) begin
      ex_q    <= slot_t'(0);
      mem_q   <= slot_t'(0);
      wb_q    <= slot_t'(0);
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: three parameterisations driven in lockstep, checked against an in-flight instruction model
module tb_hazard_ctrl;
  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] dst;
    logic       wr;
    logic       ld;
  } id_t;
  typedef struct {
    bit       v;
    bit [4:0] d;
    bit       w;
    bit       l;
  } ins_t;
  logic        clk, nrst, bt;
  logic [4:0]  rs, rt, dst;
  logic        urs, urt, wr, ld;
  logic [4:0]  ctl [3];
  logic [15:0] sc [3];
  logic [15:0] fc [3];
  bit          fwd [3] = '{1'b1, 1'b0, 1'b0};
  bit          wbb [3] = '{1'b1, 1'b0, 1'b1};
  ins_t        fl [3][3];
  int          mst [3];
  int          mfl [3];
  int          vecs = 0;
  int          errs = 0;
  localparam logic [4:0] C_RUN = 5'b11000, C_STALL = 5'b00010, C_FLUSH = 5'b11111, C_RST = 5'b00111;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_if hif ();
    assign hif.i_ID_data_RSAddr       = rs;
    assign hif.i_ID_data_RTAddr       = rt;
    assign hif.i_ID_ctrl_UsesRS       = urs;
    assign hif.i_ID_ctrl_UsesRT       = urt;
    assign hif.i_ID_data_DstAddr      = dst;
    assign hif.i_ID_ctrl_RegWrite     = wr;
    assign hif.i_ID_ctrl_MemRead      = ld;
    assign hif.i_MEM_ctrl_BranchTaken = bt;
    assign ctl[g] = {hif.o_IF_ctrl_PCWrite, hif.o_ID_ctrl_IFIDWrite, hif.o_ID_ctrl_IFIDFlush,
                     hif.o_EX_ctrl_Bubble, hif.o_MEM_ctrl_Flush};
    assign sc[g] = hif.o_stat_StallCnt;
    assign fc[g] = hif.o_stat_FlushCnt;
    hazard_ctrl #(.FORWARDING(g == 0), .WB_BYPASS(g != 1)) dut (.clk(clk), .nrst(nrst), .hz(hif));
  end

  // an older instruction at age a (0 = one ahead) blocks ID if it writes a register ID reads,
  // and the value cannot yet reach ID: with forwarding only a load one ahead is too late,
  // without forwarding the value appears only once the writer has left WB (or reached WB if bypassed)
  function automatic bit blocks(int k);
    for (int a = 0; a < 3; a++) begin
      if (fl[k][a].v && fl[k][a].w && fl[k][a].d != 0 &&
          ((urs && fl[k][a].d == rs) || (urt && fl[k][a].d == rt))) begin
        if (fwd[k] ? (a == 0 && fl[k][a].l) : (a < 2 || !wbb[k])) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [4:0] exp_ctrl(int k);
    if (!nrst) return C_RST;
    if (bt) return C_FLUSH;
    if (blocks(k)) return C_STALL;
    return C_RUN;
  endfunction

  function automatic logic [15:0] sat(int n);
    return n > 65535 ? 16'hFFFF : 16'(n);
  endfunction

  task automatic tick();
    int   md [3];
    ins_t z, nw;
    z  = '{default: 0};
    nw = '{1'b1, dst, wr, ld};
    for (int k = 0; k < 3; k++) md[k] = !nrst ? 3 : bt ? 2 : blocks(k) ? 1 : 0;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (md[k] == 3) begin
        fl[k][0] = z; fl[k][1] = z; fl[k][2] = z; mst[k] = 0; mfl[k] = 0;
      end else begin
        fl[k][2] = fl[k][1];
        fl[k][1] = md[k] == 2 ? z : fl[k][0];
        fl[k][0] = md[k] == 0 ? nw : z;
        if (md[k] == 1) mst[k]++;
        if (md[k] == 2) mfl[k]++;
      end
    end
    #1;
  endtask

  task automatic set_ins(input id_t i);
    rs = i.rs; rt = i.rt; urs = i.urs; urt = i.urt; dst = i.dst; wr = i.wr; ld = i.ld;
  endtask

  task automatic do_reset();
    id_t nop;
    nop = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0};
    set_ins(nop);
    bt = 1'b0;
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      rs = 5'($urandom); rt = 5'($urandom); dst = 5'($urandom);
      {urs, urt, wr, ld, bt} = 5'($urandom);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        vecs++;
        if ({ctl[k], sc[k], fc[k]} !== {C_RST, 16'd0, 16'd0}) begin
          errs++;
          $display("FAIL reset dut%0d ctl/stall/flush got %b/%0d/%0d want %b/0/0", k, ctl[k], sc[k], fc[k], C_RST);
        end
      end
      tick();
    end
    nrst = 1'b1;
    bt = 1'b0;
  endtask

  task automatic test_stall_windows();
    id_t first [4];
    id_t second [4];
    int  want [4][3];
    first[0]  = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1};
    second[0] = '{5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0};
    want[0]   = '{1, 3, 2};
    first[1]  = '{5'd1, 5'd1, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0};
    second[1] = '{5'd2, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0};
    want[1]   = '{0, 3, 2};
    first[2]  = first[1];
    second[2] = '{5'd2, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0};
    want[2]   = '{0, 3, 2};
    first[3]  = '{5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1};
    second[3] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0};
    want[3]   = '{0, 0, 0};
    for (int s = 0; s < 4; s++) begin
      do_reset();
      set_ins(first[s]);
      tick();
      set_ins(second[s]);
      for (int w = 0; w < 6; w++) begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          vecs++;
          if ({ctl[k], sc[k], fc[k]} !== {exp_ctrl(k), sat(mst[k]), sat(mfl[k])}) begin
            errs++;
            $display("FAIL window%0d.%0d dut%0d ctl/stall/flush got %b/%0d/%0d want %b/%0d/%0d",
                     s, w, k, ctl[k], sc[k], fc[k], exp_ctrl(k), sat(mst[k]), sat(mfl[k]));
          end
          vecs++;
          if ((ctl[k] === C_STALL) !== (w < want[s][k])) begin
            errs++;
            $display("FAIL stall_len%0d dut%0d cycle %0d stalled=%0d want stall cycles %0d",
                     s, k, w, ctl[k] === C_STALL, want[s][k]);
          end
        end
        tick();
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        vecs++;
        if (sc[k] !== 16'(want[s][k])) begin
          errs++;
          $display("FAIL stallcnt%0d dut%0d got %0d want %0d", s, k, sc[k], want[s][k]);
        end
      end
    end
  endtask

  task automatic test_branch_flush();
    do_reset();
    set_ins('{5'd1, 5'd2, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1});
    tick();
    set_ins('{5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0});
    bt = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      vecs++;
      if (ctl[k] !== C_FLUSH) begin
        errs++;
        $display("FAIL flush_ctl dut%0d got %b want %b", k, ctl[k], C_FLUSH);
      end
    end
    tick();
    bt = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      vecs++;
      if ({ctl[k], sc[k], fc[k]} !== {C_RUN, 16'd0, 16'd1}) begin
        errs++;
        $display("FAIL after_flush dut%0d ctl/stall/flush got %b/%0d/%0d want %b/0/1", k, ctl[k], sc[k], fc[k], C_RUN);
      end
    end
    tick();
  endtask

  task automatic test_saturation();
    int it = 0;
    do_reset();
    set_ins('{5'd2, 5'd2, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1});
    while (mst[1] < 65540 && it < 90000) begin
      @(negedge clk);
      if (it % 8192 == 0) begin
        for (int k = 0; k < 3; k++) begin
          vecs++;
          if ({ctl[k], sc[k], fc[k]} !== {exp_ctrl(k), sat(mst[k]), sat(mfl[k])}) begin
            errs++;
            $display("FAIL sat_run dut%0d ctl/stall/flush got %b/%0d/%0d want %b/%0d/%0d",
                     k, ctl[k], sc[k], fc[k], exp_ctrl(k), sat(mst[k]), sat(mfl[k]));
          end
        end
      end
      tick();
      it++;
    end
    @(negedge clk);
    vecs++;
    if (it >= 90000 || sc[1] !== 16'hFFFF) begin
      errs++;
      $display("FAIL saturate dut1 stallcnt got %h want ffff after %0d cycles", sc[1], it);
    end
    for (int k = 0; k < 3; k++) begin
      vecs++;
      if ({ctl[k], sc[k], fc[k]} !== {exp_ctrl(k), sat(mst[k]), sat(mfl[k])}) begin
        errs++;
        $display("FAIL sat_end dut%0d ctl/stall/flush got %b/%0d/%0d want %b/%0d/%0d",
                 k, ctl[k], sc[k], fc[k], exp_ctrl(k), sat(mst[k]), sat(mfl[k]));
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_ins('{5'd1, 5'd1, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0});
    tick();
    set_ins('{5'd2, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0});
    @(negedge clk);
    vecs++;
    if (ctl[1] !== C_STALL) begin
      errs++;
      $display("FAIL pre_reset_stall dut1 got %b want %b", ctl[1], C_STALL);
    end
    tick();
    nrst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        vecs++;
        if (ctl[k] !== C_RST || (c == 1 && (sc[k] !== 16'd0 || fc[k] !== 16'd0))) begin
          errs++;
          $display("FAIL mid_reset%0d dut%0d ctl/stall/flush got %b/%0d/%0d want %b/0/0", c, k, ctl[k], sc[k], fc[k], C_RST);
        end
      end
      tick();
    end
    nrst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      vecs++;
      if ({ctl[k], sc[k], fc[k]} !== {C_RUN, 16'd0, 16'd0}) begin
        errs++;
        $display("FAIL post_reset dut%0d ctl/stall/flush got %b/%0d/%0d want %b/0/0", k, ctl[k], sc[k], fc[k], C_RUN);
      end
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1000; c++) begin
      nrst = $urandom_range(0, 49) != 0;
      bt   = $urandom_range(0, 7) == 0;
      rs   = 5'($urandom_range(0, 3));
      rt   = 5'($urandom_range(0, 3));
      dst  = 5'($urandom_range(0, 3));
      {urs, urt, wr, ld} = 4'($urandom);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        vecs++;
        if ({ctl[k], sc[k], fc[k]} !== {exp_ctrl(k), sat(mst[k]), sat(mfl[k])}) begin
          errs++;
          $display("FAIL random%0d dut%0d ctl/stall/flush got %b/%0d/%0d want %b/%0d/%0d",
                   c, k, ctl[k], sc[k], fc[k], exp_ctrl(k), sat(mst[k]), sat(mfl[k]));
        end
      end
      tick();
    end
    nrst = 1'b1;
    bt = 1'b0;
  endtask

  initial begin
    nrst = 1'b0;
    bt = 1'b0;
    set_ins('{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0});
    test_reset();
    test_stall_windows();
    test_branch_flush();
    test_reset_mid_stall();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
